// File: rtl/btn_write_strobe.sv
// Button front-end for the 4x8 latch bank: synchronizes and debounces btnC, captures
// the switch data/bank select and emits a one-cycle one-hot write strobe per press.
module btn_write_strobe #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DATA_W          = 8,
  parameter int SEL_W           = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_raw,
  input  logic [DATA_W-1:0]     sw_data,
  input  logic [SEL_W-1:0]      sw_sel,
  output logic [(2**SEL_W)-1:0] wr_en,
  output logic [DATA_W-1:0]     wr_data,
  output logic [SEL_W-1:0]      wr_sel,
  output logic                  btn_level,
  output logic                  busy
);

  localparam int EN_W  = 2**SEL_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]        btn_sync;
  logic [DATA_W-1:0] data_meta, data_s;
  logic [SEL_W-1:0]  sel_meta, sel_s;
  logic              btn_s;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              fire;

  // Two-flop synchronizers; the switches are only sampled at capture time, so a
  // word that is mid-change for one cycle is accepted as whatever settles.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= '0;
      data_meta <= '0;
      data_s    <= '0;
      sel_meta  <= '0;
      sel_s     <= '0;
    end else begin
      btn_sync  <= {btn_sync[0], btn_raw};
      data_meta <= sw_data;
      data_s    <= data_meta;
      sel_meta  <= sw_sel;
      sel_s     <= sel_meta;
    end
  end

  assign btn_s = btn_sync[1];

  // NOTE: defaults at the top of always_comb keep every path assigned, so no
  // latches are inferred.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_s) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_PRESSED;
          fire      = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (btn_s)                 state_nxt = ST_PRESSED;
        else if (cnt == CNT_LAST)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter restarts on any state change and only runs while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if ((state == ST_ARM || state == ST_RELEASE) && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_data <= '0;
      wr_sel  <= '0;
    end else begin
      wr_en <= fire ? (EN_W'(1) << sel_s) : '0;
      if (fire) begin
        wr_data <= data_s;
        wr_sel  <= sel_s;
      end
    end
  end

  assign btn_level = (state == ST_PRESSED) || (state == ST_RELEASE);
  assign busy      = (state != ST_IDLE);

endmodule
